ps2_host_send: RTL and testbench

// - Host-to-device PS2 transmitter; the send side of the keyboard link whose receive side is ps2_scan.
// - Sends one command byte to the keyboard (0xED set-LEDs, 0xFF reset, 0xF4 enable) via the PS2 request-to-send sequence.
// - Drives the open-drain clock/data lines through active-high pull-low enables and checks the device ACK.
// - busy gates ps2_scan so host-driven frames are never decoded as key data.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_send.sv | 166 ++++++++++++++++
 tb/tb_ps2_host_send.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS2 definitions: command bytes, error codes, host-send FSM states and frame builder.
// Used by the host-to-device transmitter and the device-to-host scanner.
package ps2_pkg;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_ACK         = 8'hFA;
   localparam logic [7:0] PS2_RESEND      = 8'hFE;

   localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
   localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] PS2_ERR_NOACK   = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StStart,
      StRun,
      StAck,
      StWaitRel,
      StErr
   } ps2_tx_state_e;

   // Shift-out order is LSB first: D0..D7, odd parity, stop.
   function automatic logic [9:0] ps2_frame(input logic [7:0] b);
      return {1'b1, ~^b, b};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS2 clock and data pins plus a falling-edge pulse on the
// synchronised clock.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_sync,
   output logic data_sync,
   output logic fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   // Reset to the idle (released, high) level so no spurious fall follows reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], ps2_clk_in};
         data_ff  <= {data_ff[0], ps2_data_in};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_sync  = clk_ff[1];
   assign data_sync = data_ff[1];
   assign fall      = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_send.sv
// PS2 host-to-device transmitter: request-to-send, 11-clock frame out, device ACK check.
// Pads at chip top are open drain: ps2_clk = ps2_clk_oe ? 1'b0 : 1'bz (same for data).
module ps2_host_send
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int unsigned IhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

   ps2_tx_state_e  state_q, state_d;
   logic [9:0]     shift_q, shift_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [IhW-1:0] inh_q, inh_d;
   logic [WdW-1:0] wdog_q, wdog_d;
   logic           data_q, data_d;
   logic [1:0]     err_code_q, err_code_d;

   logic clk_sync;
   logic data_sync;
   logic fall;
   logic wd_expire;

   ps2_line_sync u_line_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_sync    (clk_sync),
      .data_sync   (data_sync),
      .fall        (fall)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         inh_q      <= '0;
         wdog_q     <= '0;
         data_q     <= 1'b0;
         err_code_q <= PS2_ERR_NONE;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         inh_q      <= inh_d;
         wdog_q     <= wdog_d;
         data_q     <= data_d;
         err_code_q <= err_code_d;
      end
   end

   assign wd_expire = (wdog_q == WdW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      inh_d      = inh_q;
      wdog_d     = wdog_q;
      data_d     = data_q;
      err_code_d = err_code_q;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               shift_d = ps2_frame(tx_data);
               inh_d   = '0;
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            if (inh_q == IhW'(INHIBIT_CYCLES - 1)) begin
               state_d = StStart;
            end else begin
               inh_d = inh_q + 1'b1;
            end
         end
         StStart: begin
            data_d    = 1'b1;
            bit_cnt_d = '0;
            wdog_d    = '0;
            state_d   = StRun;
         end
         StRun: begin
            if (fall) begin
               data_d    = ~shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               wdog_d    = '0;
               // Tenth fall put the stop bit out; the next one is the ACK slot.
               if (bit_cnt_q == 4'd9) begin
                  state_d = StAck;
               end
            end else if (wd_expire) begin
               err_code_d = PS2_ERR_TIMEOUT;
               state_d    = StErr;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StAck: begin
            if (fall) begin
               wdog_d = '0;
               if (!data_sync) begin
                  state_d = StWaitRel;
               end else begin
                  err_code_d = PS2_ERR_NOACK;
                  state_d    = StErr;
               end
            end else if (wd_expire) begin
               err_code_d = PS2_ERR_TIMEOUT;
               state_d    = StErr;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StWaitRel: begin
            if (clk_sync && data_sync) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (wd_expire) begin
               err_code_d = PS2_ERR_TIMEOUT;
               state_d    = StErr;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      tx_ready    = (state_q == StIdle);
      busy        = (state_q != StIdle);
      err         = (state_q == StErr);
      ps2_clk_oe  = (state_q == StInhibit) || (state_q == StStart);
      ps2_data_oe = (state_q == StStart) || ((state_q == StRun) && data_q);
   end

   assign err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_send.sv
// Directed bench for ps2_host_send with a small PS2 device model driving the open-drain lines.
module tb_ps2_host_send;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       bfm_clk = 1'b1;
   logic       bfm_data = 1'b1;
   logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err;
   logic [1:0] err_code;
   logic       clk_line, data_line;

   int n_total = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done = 0;
   int n_err = 0;
   int err_cyc = 0;
   int start_cyc = 0;
   logic [1:0] code_at_err = 2'b00;
   logic       oe_at_err = 1'b0;
   logic       rdy_seen = 1'b0;

   assign clk_line  = bfm_clk & ~ps2_clk_oe;
   assign data_line = bfm_data & ~ps2_data_oe;

   ps2_host_send #(
      .INHIBIT_CYCLES (8),
      .TIMEOUT_CYCLES (200)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (clk_line),
      .ps2_data_in (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done) n_done <= n_done + 1;
      if (err) begin
         n_err       <= n_err + 1;
         err_cyc     <= cyc + 1;
         code_at_err <= err_code;
         oe_at_err   <= ps2_clk_oe | ps2_data_oe;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      rdy_seen |= tx_ready;
   endtask

   // Issue a byte and measure the inhibit and start phases; returns in the first RUN cycle.
   task automatic start_send(input logic [7:0] b);
      int n_inh;
      int n_st;
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("ready_low", {31'd0, tx_ready}, 32'd0);
      n_inh = 0;
      while (ps2_clk_oe && !ps2_data_oe && n_inh < 100) begin
         n_inh++;
         tick();
      end
      n_st = 0;
      while (ps2_clk_oe && ps2_data_oe && n_st < 10) begin
         n_st++;
         start_cyc = cyc;
         tick();
      end
      check("inhibit_len", n_inh, 8);
      check("start_len", n_st, 1);
   endtask

   // Device model: 20 cycles high / 20 low per clock, samples the line mid-low.
   task automatic device_frame(input logic ack_low, input int abort_fall,
                               output logic [9:0] bits);
      int d0;
      int e0;
      int w;
      d0 = n_done;
      e0 = n_err;
      bits = '0;
      rdy_seen = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         repeat (20) tick();
         bfm_clk = 1'b0;
         if (i == 11 && ack_low) bfm_data = 1'b0;
         if (i == abort_fall) begin
            repeat (4) tick();
            rst = 1'b0;
            bfm_clk = 1'b1;
            tick();
            rst = 1'b1;
            return;
         end
         repeat (10) tick();
         if (i <= 10) bits[i-1] = data_line;
         repeat (10) tick();
         bfm_clk = 1'b1;
         bfm_data = 1'b1;
      end
      w = 0;
      while (n_done == d0 && n_err == e0 && w < 100) begin
         w++;
         tick();
      end
   endtask

   task automatic send_ok(input string name, input logic [7:0] b, input logic [9:0] exp,
                          input logic glitch);
      logic [9:0] bits;
      int d0;
      int e0;
      d0 = n_done;
      e0 = n_err;
      start_send(b);
      if (glitch) begin
         tx_data  = 8'h55;
         tx_valid = 1'b1;
         tick();
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         check({"ready_busy_", name}, {31'd0, tx_ready}, 32'd0);
      end
      device_frame(1'b1, 0, bits);
      check({"frame_", name}, {22'd0, bits}, {22'd0, exp});
      check({"parity_", name}, {31'd0, bits[8]}, {31'd0, exp[8]});
      check({"done_", name}, n_done - d0, 1);
      check({"noerr_", name}, n_err - e0, 0);
      if (glitch) check({"ready_until_done_", name}, {31'd0, rdy_seen}, 32'd0);
      tick();
      check({"ready_back_", name}, {31'd0, tx_ready}, 32'd1);
   endtask

   initial begin
      logic [9:0] bits;
      int d0;
      int e0;
      int w;

      repeat (3) tick();
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("rst_pulses", {30'd0, done, err}, 32'd0);
      check("rst_code", {30'd0, err_code}, 32'd0);
      rst = 1'b1;
      repeat (2) tick();

      // 0xED: 6 ones -> odd parity bit 1.
      send_ok("ed", PS2_CMD_SET_LED, 10'h3ED, 1'b0);
      send_ok("00", 8'h00, 10'h300, 1'b0);
      send_ok("ff", 8'hFF, 10'h3FF, 1'b0);
      send_ok("01", 8'h01, 10'h201, 1'b0);

      // No ACK: device leaves data high in the ACK slot.
      d0 = n_done;
      e0 = n_err;
      start_send(PS2_CMD_SET_LED);
      device_frame(1'b0, 0, bits);
      check("noack_err", n_err - e0, 1);
      check("noack_code", {30'd0, code_at_err}, {30'd0, PS2_ERR_NOACK});
      check("noack_oe", {31'd0, oe_at_err}, 32'd0);
      check("noack_nodone", n_done - d0, 0);
      repeat (5) tick();

      // Timeout: device never clocks.
      d0 = n_done;
      e0 = n_err;
      start_send(PS2_CMD_RESET);
      w = 0;
      while (n_err == e0 && w < 400) begin
         w++;
         tick();
      end
      check("to_err", n_err - e0, 1);
      check("to_cycle", err_cyc - start_cyc, 201);
      check("to_code", {30'd0, code_at_err}, {30'd0, PS2_ERR_TIMEOUT});
      check("to_oe", {31'd0, oe_at_err}, 32'd0);
      check("to_nodone", n_done - d0, 0);
      repeat (5) tick();

      // Reset mid-frame at fall 5.
      d0 = n_done;
      e0 = n_err;
      start_send(PS2_CMD_SET_LED);
      device_frame(1'b1, 5, bits);
      check("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("abort_ready", {31'd0, tx_ready}, 32'd1);
      repeat (10) tick();
      check("abort_pulses", (n_done - d0) + (n_err - e0), 0);

      // Resend after reset, with a request during busy that must be ignored.
      send_ok("f4", PS2_CMD_ENABLE, 10'h2F4, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
